// File: rtl/uart_rx_ram_buf_if.sv
// Bundle of the UART receive side, consumer read side and status outputs
// of the byte buffer; the buffer itself takes the slave view.
interface uart_rx_ram_buf_if #(
   parameter int AW = 4
);
   logic [7:0]  rx_data;
   logic        rx_int;
   logic        rd_en;
   logic        clr_ovf;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        empty;
   logic        full;
   logic [AW:0] count;
   logic        overflow;
   logic        byte_done;

   modport master (
      output rx_data, rx_int, rd_en, clr_ovf,
      input  rd_data, rd_valid, empty, full, count, overflow, byte_done
   );

   modport slave (
      input  rx_data, rx_int, rd_en, clr_ovf,
      output rd_data, rd_valid, empty, full, count, overflow, byte_done
   );
endinterface

// File: rtl/uart_rx_ram_buf.sv
// Byte buffer behind a UART receiver: each falling edge of the busy flag
// pushes rx_data into a circular RAM, drained one byte per rd_en cycle.
module uart_rx_ram_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input logic              clk,
   input logic              rst,
   uart_rx_ram_buf_if.slave bus
);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [7:0]    mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          rd_valid_q;
   logic          overflow_q, overflow_d;
   logic          rx_int_q;
   logic          byte_done_q;

   logic          empty;
   logic          full;
   logic          frame_end;
   logic          rd_accept;
   logic          wr_accept;
   logic          wr_drop;

   // Flags come only from registered count, so rd_en/rx_int never reach them.
   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_FULL);
   assign frame_end = rx_int_q & ~bus.rx_int;
   assign rd_accept = bus.rd_en & ~empty;
   assign wr_accept = frame_end & (~full | rd_accept);
   assign wr_drop   = frame_end & ~wr_accept;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      overflow_d = overflow_q;

      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_accept) begin
         rd_ptr_d  = rd_ptr_q + PTR_ONE;
         rd_data_d = mem_q[rd_ptr_q];
      end

      case ({wr_accept, rd_accept})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // A drop in the same cycle as clr_ovf keeps the flag set.
      if (bus.clr_ovf) begin
         overflow_d = 1'b0;
      end
      if (wr_drop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         rx_int_q    <= 1'b0;
         byte_done_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_accept;
         overflow_q  <= overflow_d;
         rx_int_q    <= bus.rx_int;
         byte_done_q <= frame_end;
      end
   end

   // Storage is not reset; a full-and-reading write hits the slot being read,
   // which returns the old byte because the read samples before the edge.
   always_ff @(posedge clk) begin
      if (!rst && wr_accept) begin
         mem_q[wr_ptr_q] <= bus.rx_data;
      end
   end

   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.empty     = empty;
   assign bus.full      = full;
   assign bus.count     = count_q;
   assign bus.overflow  = overflow_q;
   assign bus.byte_done = byte_done_q;
endmodule

// File: doc/uart_rx_ram_buf.md
UART_RX_RAM_BUF -- requirements
Module: uart_rx_ram_buf

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the number of byte entries in the buffer RAM (power of two).
REQ-002 Parameter AW, default 4, SHALL set the address width and SHALL equal log2(DEPTH).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 rx_data  input  8  SHALL be the received byte from the upstream UART receiver, valid when rx_int falls.
REQ-006 rx_int  input  1  SHALL be the receiver busy flag: high while a frame is being received, low when idle.
REQ-007 rd_en  input  1  SHALL be the consumer read request, one byte per asserted cycle.
REQ-008 clr_ovf  input  1  SHALL clear the sticky overflow flag.
REQ-009 rd_data  output  8  SHALL be the byte returned by an accepted read.
REQ-010 rd_valid  output  1  SHALL be a one-cycle strobe qualifying rd_data.
REQ-011 empty  output  1  SHALL be high when count is 0.
REQ-012 full  output  1  SHALL be high when count equals DEPTH.
REQ-013 count  output  AW+1  SHALL be the number of stored bytes, 0..DEPTH.
REQ-014 overflow  output  1  SHALL be a sticky flag marking at least one dropped byte.
REQ-015 byte_done  output  1  SHALL be a one-cycle strobe marking each detected end of frame.

Function
REQ-016 The block SHALL register rx_int into rx_int_d each cycle and detect end of frame as rx_int_d=1 and rx_int=0.
REQ-017 byte_done SHALL assert in the cycle after the detecting edge and stay high for exactly one cycle per falling edge.
REQ-018 On a detected end of frame, the block SHALL sample rx_data in the same cycle as the edge detection.
REQ-019 A write SHALL be accepted when full=0, or when full=1 and a read is accepted in the same cycle.
REQ-020 An accepted write SHALL store the byte at wr_ptr and increment wr_ptr modulo DEPTH.
REQ-021 A write arriving when full=1 with no accepted read SHALL be dropped, leaving RAM, wr_ptr and count unchanged.
REQ-022 A dropped write SHALL set overflow to 1 on the next edge.
REQ-023 overflow SHALL stay 1 until clr_ovf=1 or rst=1.
REQ-024 If clr_ovf and a drop coincide, the drop SHALL win and overflow SHALL remain 1.
REQ-025 A read SHALL be accepted only when rd_en=1 and empty=0.
REQ-026 An accepted read SHALL set rd_data to RAM[rd_ptr] and rd_valid to 1 on the next edge, and increment rd_ptr modulo DEPTH.
REQ-027 rd_en while empty=1 SHALL be ignored: rd_valid=0, rd_data holds, and no error flag is set.
REQ-028 A write and read accepted in the same cycle SHALL leave count unchanged.
REQ-029 When empty=1, a same-cycle write and rd_en SHALL accept the write only (no read-through).
REQ-030 count SHALL be +1 on a write only, -1 on a read only, and otherwise unchanged.
REQ-031 empty and full SHALL be derived from registered count, with no combinational path from rd_en or rx_int.
REQ-032 Read latency SHALL be 1 cycle (rd_en edge to rd_valid).
REQ-033 Write-to-visible latency SHALL be 2 cycles: falling rx_int, then 1 cycle to empty=0.
REQ-034 Pointer wrap-around SHALL be seamless, with no skipped or repeated entries over any number of wraps.

Reset
REQ-035 When rst=1 at a clock edge, wr_ptr, rd_ptr, count, rx_int_d, rd_data, rd_valid, overflow and byte_done SHALL all be 0.
REQ-036 After reset, empty SHALL be 1 and full SHALL be 0.
REQ-037 RAM contents SHALL NOT be reset and SHALL be unobservable until rewritten.
REQ-038 Reset asserted mid-operation SHALL discard all stored bytes and any pending edge.
REQ-039 A falling rx_int in the cycle reset deasserts SHALL NOT be captured, because rx_int_d=0.

Verification
REQ-040 Scenario 1: three frames 0x55, 0xA3, 0x0F, then three rd_en pulses -> rd_data 0x55, 0xA3, 0x0F each with rd_valid; count 3 -> 0; empty=1.
REQ-041 Scenario 2: 17 frames with no reads -> count=16, full=1, overflow=1; reads return the first 16 bytes in order; the 17th byte is absent.
REQ-042 Scenario 3: with full=1, a frame ends in the same cycle as rd_en -> count stays 16 and overflow stays 0; the new byte is read last.
REQ-043 Scenario 4: with empty=1, rd_en=1 for 3 cycles -> rd_valid stays 0 and count stays 0; then frame 0xC3 with rd_en held high -> rd_valid one cycle after empty falls, rd_data=0xC3.
REQ-044 Scenario 5: 40 frames interleaved with reads, occupancy between 1 and 5 -> output sequence equals input sequence across two pointer wraps.
REQ-045 Scenario 6: with count=5 and overflow=1, assert rst for 1 cycle -> count=0, empty=1, overflow=0, rd_valid=0; a subsequent clr_ovf has no effect.
